uart_tx_sched: RTL

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_tx_sched_rr_arbiter.sv | 26 ++
 rtl/uart_tx_sched.sv | 87 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and shared constants for the UART transmit scheduler.
package uart_pkg;
    localparam int BYTE_W = 8;
    localparam logic [15:0] DEF_TIMEOUT = 16'd60000;
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_gnt_i+1.
// With UART_TX_SCHED_PRIO_EN defined, requester 0 overrides the rotation.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [1:0]      last_gnt_i,
    output logic            any_o,
    output logic [1:0]      winner_o
);
    int k;
    always_comb begin
        any_o = |req_i;
        winner_o = '0;
        k = 0;
        // Descending scan so the nearest requester after last_gnt_i wins.
        for (int i = NREQ; i >= 1; i--) begin
            k = (int'(last_gnt_i) + i) % NREQ;
            if (|(req_i & (NREQ'(1) << k))) winner_o = 2'(k);
        end
`ifdef UART_TX_SCHED_PRIO_EN
        if (req_i[0]) winner_o = '0;
`else
`endif
    end
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates bytes from NREQ requesters into one UART transmitter with a done watchdog.
// Define UART_TX_SCHED_PRIO_EN to give requester 0 absolute priority over the rotation.
module uart_tx_sched import uart_pkg::*; #(
    parameter int          NREQ    = 4,
    parameter logic [15:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [BYTE_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     tx_start,
    output logic [BYTE_W-1:0]        tx_din,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [1:0]               gnt_id,
    output logic                     sent,
    output logic                     err
);
    state_t state_q, state_d;
    logic [BYTE_W-1:0] din_q, din_d;
    logic [1:0] gnt_q, gnt_d, last_q, last_d, win;
    logic [15:0] wd_q, wd_d;
    logic [NREQ-1:0] rdy;
    logic any;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i(req_valid), .last_gnt_i(last_q), .any_o(any), .winner_o(win)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            din_q   <= '0;
            gnt_q   <= '0;
            last_q  <= 2'(NREQ - 1);
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end

    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wd_d    = wd_q;
        rdy     = '0;
        sent    = 1'b0;
        err     = 1'b0;
        case (state_q)
            IDLE: if (any) begin
                rdy     = NREQ'(1) << win;
                din_d   = BYTE_W'(req_data >> (BYTE_W * win));
                gnt_d   = win;
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: if (tx_done) begin
                sent    = 1'b1;
                last_d  = gnt_q;
                state_d = IDLE;
            end else if (wd_q == TIMEOUT - 16'd1) begin
                err     = 1'b1;
                last_d  = gnt_q;
                state_d = IDLE;
            end else begin
                wd_d = (wd_q == '1) ? wd_q : wd_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The grant pulse is combinational, so mask it while reset is held.
    assign req_ready = rst ? '0 : rdy;
    assign tx_start  = state_q == START;
    assign busy      = state_q != IDLE;
    assign tx_din    = din_q;
    assign gnt_id    = gnt_q;
endmodule
